uart_rx_deserializer: RTL and testbench

//  UART receive front end: oversamples the asynchronous serial line, recovers 8N1 frames
//  (8E1 with parity option) and presents the last good byte plus its two nibbles.

---
 rtl/uart_rx_deserializer.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
//   UART receive front end. Oversamples the asynchronous serial line, recovers 8N1 frames
//   (8E1 when UART_RX_PARITY_EN is defined) and presents the last good byte plus its two
//   nibbles for the 7-segment decoders downstream.
//
// Build option
//   UART_RX_PARITY_EN  defined: 8E1 frame with even parity check.
//                      undefined: 8N1 frame, parity_error tied low.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active high
//   rx_serial    in   asynchronous serial line, idle high
//   rx_data      out  last correctly received byte
//   data_hi      out  rx_data[7:4]
//   data_lo      out  rx_data[3:0]
//   data_valid   out  one-cycle pulse, rx_data updated this cycle
//   frame_error  out  one-cycle pulse, stop bit sampled low
//   parity_error out  one-cycle pulse, parity mismatch
//   rx_busy      out  high while not idle
module uart_rx_deserializer #(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic [3:0] data_hi,
  output logic [3:0] data_lo,
  output logic       data_valid,
  output logic       frame_error,
  output logic       parity_error,
  output logic       rx_busy
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMid  = CntW'(CLKS_PER_BIT / 2);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            sync1_q, sync2_q;
  logic            line;

`ifdef UART_RX_PARITY_EN
  logic            parity_q, parity_d;
  logic            perr_q, perr_d;
`endif

  // Two-flop synchroniser; reset to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_serial;
      sync2_q <= sync1_q;
    end
  end

  assign line = sync2_q;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_d  = parity_q;
    perr_d    = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!line) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (clk_cnt_q == CntMid) begin
          clk_cnt_d = '0;
          // A start bit that has gone high again by mid-bit is treated as a glitch.
          state_d   = line ? StIdle : StData;
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (clk_cnt_q == CntLast) begin
          clk_cnt_d = '0;
          shift_d   = {line, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end

      StParity: begin
`ifdef UART_RX_PARITY_EN
        if (clk_cnt_q == CntLast) begin
          clk_cnt_d = '0;
          parity_d  = line;
          state_d   = StStop;
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
`else
        state_d = StIdle;
`endif
      end

      StStop: begin
        if (clk_cnt_q == CntLast) begin
          clk_cnt_d = '0;
          if (!line) begin
            // Bad stop bit wins over any parity result.
            ferr_d  = 1'b1;
            state_d = StWaitIdle;
          end else begin
            // Leave at mid stop bit so a start bit half a bit later is still caught.
            state_d = StIdle;
`ifdef UART_RX_PARITY_EN
            if (^{shift_q, parity_q}) begin
              perr_d = 1'b1;
            end else begin
              rx_data_d = shift_q;
              valid_d   = 1'b1;
            end
`else
            rx_data_d = shift_q;
            valid_d   = 1'b1;
`endif
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end

      StWaitIdle: begin
        // Hold off until the line returns high so a break does not re-trigger a frame.
        clk_cnt_d = '0;
        if (line) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q  <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      parity_q  <= parity_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign data_hi     = rx_data_q[7:4];
  assign data_lo     = rx_data_q[3:0];
  assign data_valid  = valid_q;
  assign frame_error = ferr_q;
  assign rx_busy     = (state_q != StIdle);

`ifdef UART_RX_PARITY_EN
  assign parity_error = perr_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer
//   Directed bench for uart_rx_deserializer at default parameters (434 clocks per bit).
//   A table of frames is driven and checked, then hand-written sequences cover the glitch,
//   back-to-back, mid-frame reset and parity cases.
module tb_uart_rx_deserializer;

  localparam int unsigned Cpb = 50000000 / 115200;

  logic       clk;
  logic       rst;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic [3:0] data_hi;
  logic [3:0] data_lo;
  logic       data_valid;
  logic       frame_error;
  logic       parity_error;
  logic       rx_busy;

  uart_rx_deserializer dut (
    .clk          (clk),
    .rst          (rst),
    .rx_serial    (rx_serial),
    .rx_data      (rx_data),
    .data_hi      (data_hi),
    .data_lo      (data_lo),
    .data_valid   (data_valid),
    .frame_error  (frame_error),
    .parity_error (parity_error),
    .rx_busy      (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int         n_valid = 0;
  int         n_ferr  = 0;
  int         n_perr  = 0;
  int         last_valid_cyc = 0;
  logic       multi = 1'b0;
  logic [7:0] cap_q[$];

  always @(negedge clk) begin
    if (data_valid) begin
      n_valid++;
      cap_q.push_back(rx_data);
      last_valid_cyc = cyc;
    end
    if (frame_error) n_ferr++;
    if (parity_error) n_perr++;
    if ((int'(data_valid) + int'(frame_error) + int'(parity_error)) > 1) multi = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Holds the line at b for one bit time; entered and left 1 time unit after a rising edge.
  task automatic drive_bit(input logic b);
    rx_serial = b;
    repeat (Cpb) @(posedge clk);
    #1;
  endtask

  int start_cyc = 0;

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b);
`else
    if (par_b === 1'bx) $display("parity bit unused");
`endif
    drive_bit(stop_b);
    rx_serial = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rx_serial = 1'b1;
    repeat (n * Cpb) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[3];

  int v0, f0, p0;
  int lat;

  initial begin
    vecs[0] = '{data: 8'h41, stop_bit: 1'b1, exp_data: 8'h41, exp_valid: 1, exp_ferr: 0};
    vecs[1] = '{data: 8'h5A, stop_bit: 1'b0, exp_data: 8'h41, exp_valid: 0, exp_ferr: 1};
    vecs[2] = '{data: 8'h33, stop_bit: 1'b1, exp_data: 8'h33, exp_valid: 1, exp_ferr: 0};

    rst       = 1'b1;
    rx_serial = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_data_hi", data_hi, 4'h0);
    check("reset_data_lo", data_lo, 4'h0);
    check("reset_busy", rx_busy, 1'b0);
    check("reset_pulses", {data_valid, frame_error, parity_error}, 3'b000);
    rst = 1'b0;
    idle_bits(1);

    // Table-driven frames, each followed by two idle bit times.
    for (int i = 0; i < 3; i++) begin
      v0 = n_valid;
      f0 = n_ferr;
      p0 = n_perr;
      send_frame(vecs[i].data, vecs[i].stop_bit, ^vecs[i].data);
      if (i == 0) lat = last_valid_cyc - start_cyc;
      idle_bits(2);
      check($sformatf("v%0d_valid_cnt", i), n_valid - v0, vecs[i].exp_valid);
      check($sformatf("v%0d_ferr_cnt", i), n_ferr - f0, vecs[i].exp_ferr);
      check($sformatf("v%0d_perr_cnt", i), n_perr - p0, 0);
      check($sformatf("v%0d_rx_data", i), rx_data, vecs[i].exp_data);
      check($sformatf("v%0d_data_hi", i), data_hi, vecs[i].exp_data[7:4]);
      check($sformatf("v%0d_data_lo", i), data_lo, vecs[i].exp_data[3:0]);
      check($sformatf("v%0d_busy", i), rx_busy, 1'b0);
    end
    // Start edge to data_valid is about 9.5 bit times plus 3 clocks (4126).
    check("latency_in_window", (lat >= 4120 && lat <= 4132), 1'b1);

    // 100-clock low glitch: detected as a start, abandoned at mid start bit.
    v0 = n_valid;
    f0 = n_ferr;
    p0 = n_perr;
    @(posedge clk);
    #1;
    rx_serial = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("glitch_busy_mid", rx_busy, 1'b1);
    repeat (50) @(posedge clk);
    #1;
    rx_serial = 1'b1;
    repeat (140) @(posedge clk);
    #1;
    check("glitch_busy_end", rx_busy, 1'b0);
    check("glitch_pulses", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0), 0);
    check("glitch_rx_data", rx_data, 8'h33);
    idle_bits(1);

    // Back-to-back frames with a single stop bit.
    cap_q.delete();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle_bits(2);
    check("b2b_count", cap_q.size(), 2);
    if (cap_q.size() == 2) begin
      check("b2b_first", cap_q[0], 8'h00);
      check("b2b_second", cap_q[1], 8'hFF);
    end
    check("b2b_rx_data", rx_data, 8'hFF);

    // Reset in the middle of the data bits of 8'hA5.
    @(posedge clk);
    #1;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    check("rstmid_busy_before", rx_busy, 1'b1);
    rx_serial = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_rx_data", rx_data, 8'h00);
    check("rstmid_nibbles", {data_hi, data_lo}, 8'h00);
    check("rstmid_busy", rx_busy, 1'b0);
    check("rstmid_pulses", {data_valid, frame_error, parity_error}, 3'b000);
    rst = 1'b0;
    idle_bits(2);
    v0 = n_valid;
    send_frame(8'h0F, 1'b1, 1'b0);
    idle_bits(2);
    check("after_rst_valid_cnt", n_valid - v0, 1);
    check("after_rst_rx_data", rx_data, 8'h0F);

`ifdef UART_RX_PARITY_EN
    // 8'h41 has two ones, so the even parity bit is 0.
    v0 = n_valid;
    p0 = n_perr;
    send_frame(8'h41, 1'b1, 1'b1);
    idle_bits(2);
    check("par_bad_perr_cnt", n_perr - p0, 1);
    check("par_bad_valid_cnt", n_valid - v0, 0);
    check("par_bad_rx_data", rx_data, 8'h0F);
    v0 = n_valid;
    p0 = n_perr;
    send_frame(8'h41, 1'b1, 1'b0);
    idle_bits(2);
    check("par_good_perr_cnt", n_perr - p0, 0);
    check("par_good_valid_cnt", n_valid - v0, 1);
    check("par_good_rx_data", rx_data, 8'h41);
`endif

    check("one_pulse_max", multi, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
